// File: rtl/ppu_fetch_pkg.sv
// ppu_fetch_pkg: state encoding, window-decode widths and helpers shared by the
// PPU fetch bridge. Optional prefetch states exist only with PPU_FETCH_PREFETCH_EN.
package ppu_fetch_pkg;

    localparam int PPU_ADDR_W = 14;
    localparam int PPU_MEM_AW = 13;
    localparam int LAT_CNT_W  = 2;

`ifdef PPU_FETCH_PREFETCH_EN
    typedef enum logic [2:0] {
        ST_IDLE, ST_FETCH, ST_WAIT, ST_CAPTURE, ST_PF_FETCH, ST_PF_WAIT
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE, ST_FETCH, ST_WAIT, ST_CAPTURE
    } state_t;
`endif

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/ppu_lat_counter.sv
// ppu_lat_counter: memory read-latency timer; reloads MEM_LAT-1, counts down, flags zero.
module ppu_lat_counter
    import ppu_fetch_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    output logic o_done
);

    logic [LAT_CNT_W-1:0] r_cnt;

    // reload while not timing a read, otherwise count down and stop at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= LAT_CNT_W'(MEM_LAT - 1);
        else if (r_cnt != '0)
            r_cnt <= r_cnt - LAT_CNT_W'(1);
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/ppu_fetch_bridge.sv
// ppu_fetch_bridge: turns PPU address reads into single memory fetches with a
// registered data return and last-address caching. Define PPU_FETCH_PREFETCH_EN
// to add a one-entry next-address prefetch buffer.
module ppu_fetch_bridge
    import ppu_fetch_pkg::*;
#(
    parameter int                ADDR_W     = PPU_ADDR_W,
    parameter int                MEM_AW     = PPU_MEM_AW,
    parameter int                DATA_W     = 8,
    parameter int                MEM_LAT    = 1,
    parameter logic [DATA_W-1:0] FILL_VALUE = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] ppu_addr,
    input  logic              ppu_rd,
    output logic [DATA_W-1:0] ppu_data,
    output logic              ppu_busy,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_en,
    input  logic [DATA_W-1:0] mem_dout,
    input  logic              mem_ready,
    output logic [15:0]       fetch_cnt
);

    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_tmp_addr, r_last_addr;
    logic              r_last_vld;
    logic [DATA_W-1:0] r_data;
    logic [MEM_AW-1:0] r_mem_addr;
    logic [15:0]       r_fetch_cnt;
    logic              w_in_win, w_start, w_lat_load, w_lat_done;

    assign w_in_win = (ppu_addr[ADDR_W-1:MEM_AW] == '0);
    assign w_start  = ppu_rd && w_in_win && (!r_last_vld || ppu_addr != r_last_addr);

`ifdef PPU_FETCH_PREFETCH_EN
    logic [ADDR_W-1:0] r_pf_addr;
    logic [DATA_W-1:0] r_pf_buf;
    logic              r_pf_vld;
    logic              w_pf_hit, w_pf_go;
    logic [ADDR_W-1:0] w_pf_src;

    // a request served from the buffer; its successor (or the captured address's) is prefetched
    assign w_pf_hit = (r_state == ST_IDLE) && w_start && r_pf_vld && (ppu_addr == r_pf_addr);
    assign w_pf_src = w_pf_hit ? ppu_addr : r_tmp_addr;
    assign w_pf_go  = (w_pf_src[MEM_AW-1:0] != '1);
`endif

    ppu_lat_counter #(.MEM_LAT(MEM_LAT)) u_lat (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_lat_load),
        .o_done (w_lat_done)
    );

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    // next state, read strobe and latency-timer control
    always_comb begin
        w_next     = r_state;
        mem_en     = 1'b0;
        w_lat_load = 1'b1;
        case (r_state)
            ST_IDLE: begin
`ifdef PPU_FETCH_PREFETCH_EN
                if (w_pf_hit)
                    w_next = w_pf_go ? ST_PF_FETCH : ST_IDLE;
                else
`endif
                if (w_start)
                    w_next = ST_FETCH;
            end
            ST_FETCH: begin
                mem_en     = mem_ready;
                w_lat_load = 1'b0;
                w_next     = !mem_ready ? ST_IDLE : (w_lat_done ? ST_CAPTURE : ST_WAIT);
            end
            ST_WAIT: begin
                w_lat_load = 1'b0;
                if (w_lat_done)
                    w_next = ST_CAPTURE;
            end
`ifdef PPU_FETCH_PREFETCH_EN
            ST_CAPTURE:  w_next = w_pf_go ? ST_PF_FETCH : ST_IDLE;
            ST_PF_FETCH: begin
                mem_en = mem_ready;
                w_next = mem_ready ? ST_PF_WAIT : ST_IDLE;
            end
            ST_PF_WAIT: begin
                w_lat_load = 1'b0;
                if (w_lat_done)
                    w_next = ST_IDLE;
            end
`else
            ST_CAPTURE:  w_next = ST_IDLE;
`endif
            default:     w_next = ST_IDLE;
        endcase
    end

    // fetch address latching, data return, last-address cache and fetch counting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmp_addr  <= '0;
            r_last_addr <= '0;
            r_last_vld  <= 1'b0;
            r_data      <= '0;
            r_mem_addr  <= '0;
            r_fetch_cnt <= '0;
`ifdef PPU_FETCH_PREFETCH_EN
            r_pf_addr   <= '0;
            r_pf_buf    <= '0;
            r_pf_vld    <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
`ifdef PPU_FETCH_PREFETCH_EN
                    if (w_pf_hit) begin
                        r_data      <= r_pf_buf;
                        r_last_addr <= ppu_addr;
                        r_last_vld  <= 1'b1;
                        r_tmp_addr  <= ppu_addr;
                    end else
`endif
                    if (w_start) begin
                        r_tmp_addr <= ppu_addr;
                        r_mem_addr <= ppu_addr[MEM_AW-1:0];
                    end
                end
                ST_FETCH: begin
                    if (!mem_ready)
                        r_data <= FILL_VALUE;
                end
                ST_CAPTURE: begin
                    r_data      <= mem_dout;
                    r_last_addr <= r_tmp_addr;
                    r_last_vld  <= 1'b1;
                    r_fetch_cnt <= sat_inc(r_fetch_cnt);
                end
`ifdef PPU_FETCH_PREFETCH_EN
                ST_PF_WAIT: begin
                    if (w_lat_done) begin
                        r_pf_buf    <= mem_dout;
                        r_pf_vld    <= 1'b1;
                        r_fetch_cnt <= sat_inc(r_fetch_cnt);
                    end
                end
`endif
                default: ;
            endcase
`ifdef PPU_FETCH_PREFETCH_EN
            if (w_pf_hit || r_state == ST_CAPTURE) begin
                r_pf_vld <= 1'b0;
                if (w_pf_go) begin
                    r_pf_addr  <= w_pf_src + ADDR_W'(1);
                    r_mem_addr <= w_pf_src[MEM_AW-1:0] + MEM_AW'(1);
                end
            end
`endif
        end
    end

    assign ppu_data  = r_data;
    assign ppu_busy  = (r_state != ST_IDLE);
    assign mem_addr  = r_mem_addr;
    assign fetch_cnt = r_fetch_cnt;

endmodule

// File: tb/tb_ppu_fetch_bridge.sv
// tb_ppu_fetch_bridge: scoreboard bench for ppu_fetch_bridge with MEM_LAT=1 and MEM_LAT=3 instances.
`timescale 1ns/1ps
module tb_ppu_fetch_bridge;

    localparam logic [7:0] FILL = 8'hEE;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n1, rst_n3, ppu_rd, mem_ready;
    logic [13:0] ppu_addr;
    logic [7:0]  d1_data, d3_data, dout1, dout3;
    logic        d1_busy, d3_busy, d1_en, d3_en;
    logic [12:0] d1_maddr, d3_maddr;
    logic [15:0] d1_cnt, d3_cnt;

    ppu_fetch_bridge #(.MEM_LAT(1), .FILL_VALUE(FILL)) u_dut1 (
        .clk(clk), .rst_n(rst_n1), .ppu_addr(ppu_addr), .ppu_rd(ppu_rd),
        .ppu_data(d1_data), .ppu_busy(d1_busy), .mem_addr(d1_maddr), .mem_en(d1_en),
        .mem_dout(dout1), .mem_ready(mem_ready), .fetch_cnt(d1_cnt)
    );

    ppu_fetch_bridge #(.MEM_LAT(3), .FILL_VALUE(FILL)) u_dut3 (
        .clk(clk), .rst_n(rst_n3), .ppu_addr(ppu_addr), .ppu_rd(ppu_rd),
        .ppu_data(d3_data), .ppu_busy(d3_busy), .mem_addr(d3_maddr), .mem_en(d3_en),
        .mem_dout(dout3), .mem_ready(mem_ready), .fetch_cnt(d3_cnt)
    );

    // memory contents: byte at address a is a[7:0]^0xB5 (0x010 holds 0xA5)
    function automatic logic [7:0] memval(input logic [12:0] a);
        return a[7:0] ^ 8'hB5;
    endfunction

    logic [7:0] pipe1;
    logic [7:0] pipe3 [3];
    always @(posedge clk) begin
        pipe1    <= d1_en ? memval(d1_maddr) : 8'h00;
        pipe3[0] <= d3_en ? memval(d3_maddr) : 8'h00;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign dout1 = pipe1;
    assign dout3 = pipe3[2];

    typedef struct {
        logic [7:0]  data;
        logic [15:0] cnt;
        int          cyc;
    } exp_t;

    logic [12:0] qa[$];
    exp_t        qd[$];
    int          n_tests = 0, n_fail = 0, cyc = 0, men1 = 0, men3 = 0, ndone = 0;
    logic [15:0] prev1 = '0, prev3 = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic mon(input string tag, input logic en, input logic [12:0] ma, input logic [7:0] pd,
                       input logic [15:0] fc, input logic [15:0] pv, input logic rn);
        exp_t        e;
        logic [12:0] a;
        if (en) begin
            if (qa.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s_unexpected_mem_en: got mem_addr 0x%0h, expected no strobe", tag, ma);
            end else begin
                a = qa.pop_front();
                chk({tag, "_mem_addr"}, 32'(ma), 32'(a));
            end
        end
        if (rn && fc == pv + 16'd1) begin
            if (qd.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s_unexpected_fetch: got fetch_cnt %0d, expected no completion", tag, fc);
            end else begin
                e = qd.pop_front();
                chk({tag, "_ppu_data"}, 32'(pd), 32'(e.data));
                chk({tag, "_fetch_cnt"}, 32'(fc), 32'(e.cnt));
                if (e.cyc >= 0)
                    chk({tag, "_latency_cycle"}, 32'(cyc), 32'(e.cyc));
                ndone++;
            end
        end
    endtask

    // monitor: compares every mem_en strobe and every completed fetch against the queues
    always @(negedge clk) begin
        if (d1_en) men1++;
        if (d3_en) men3++;
        mon("d1", d1_en, d1_maddr, d1_data, d1_cnt, prev1, rst_n1);
        mon("d3", d3_en, d3_maddr, d3_data, d3_cnt, prev3, rst_n3);
        prev1 = d1_cnt;
        prev3 = d3_cnt;
    end

    task automatic expect_fetch(input logic [12:0] a, input logic [15:0] cnt, input int cyc_at);
        exp_t e;
        qa.push_back(a);
        e.data = memval(a);
        e.cnt  = cnt;
        e.cyc  = cyc_at;
        qd.push_back(e);
    endtask

    task automatic drive(input logic [13:0] a, input logic rd);
        @(posedge clk);
        #1;
        ppu_addr = a;
        ppu_rd   = rd;
    endtask

    task automatic wait_done(input int target);
        int budget = 60;
        while (ndone < target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (ndone < target) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_done: got %0d completions, expected %0d", ndone, target);
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish before 100us");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, m;
        rst_n1 = 1'b0; rst_n3 = 1'b0; ppu_addr = '0; ppu_rd = 1'b0; mem_ready = 1'b1;
        idle_cycles(3);
        chk("rst_d1_data", 32'(d1_data), 32'h0);
        chk("rst_d1_busy", 32'(d1_busy), 32'h0);
        chk("rst_d1_cnt", 32'(d1_cnt), 32'h0);
        chk("rst_d1_mem_en", 32'(d1_en), 32'h0);
        chk("rst_d1_mem_addr", 32'(d1_maddr), 32'h0);
        chk("rst_d3_data", 32'(d3_data), 32'h0);
        chk("rst_d3_busy", 32'(d3_busy), 32'h0);
        chk("rst_d3_cnt", 32'(d3_cnt), 32'h0);

        @(posedge clk); #1 rst_n1 = 1'b1;
        drive(14'h0010, 1'b1);
        t0 = cyc;
        expect_fetch(13'h010, 16'd1, t0 + 3);
        wait_done(1);
        chk("first_data_a5", 32'(d1_data), 32'hA5);

        m = men1;
        idle_cycles(20);
        chk("hold_no_mem_en", 32'(men1), 32'(m));
        chk("hold_cnt", 32'(d1_cnt), 32'd1);

        @(posedge clk); #1 mem_ready = 1'b0; ppu_addr = 14'h0020;
        m = men1;
        idle_cycles(8);
        chk("notready_fill", 32'(d1_data), 32'(FILL));
        chk("notready_no_mem_en", 32'(men1), 32'(m));
        chk("notready_cnt", 32'(d1_cnt), 32'd1);
        expect_fetch(13'h020, 16'd2, -1);
        @(posedge clk); #1 mem_ready = 1'b1;
        wait_done(2);
        chk("retry_data", 32'(d1_data), 32'h95);

        m = men1;
        drive(14'h2010, 1'b1);
        idle_cycles(10);
        chk("oow_no_mem_en", 32'(men1), 32'(m));
        chk("oow_data_held", 32'(d1_data), 32'h95);
        drive(14'h0030, 1'b0);
        idle_cycles(10);
        chk("rd0_no_mem_en", 32'(men1), 32'(m));
        chk("rd0_data_held", 32'(d1_data), 32'h95);
        chk("rd0_not_busy", 32'(d1_busy), 32'h0);
        drive(14'h0030, 1'b1);
        t0 = cyc;
        expect_fetch(13'h030, 16'd3, t0 + 3);
        wait_done(3);
        chk("rd1_data", 32'(d1_data), 32'h85);

        drive(14'h0040, 1'b1);
        @(posedge clk); #1 rst_n1 = 1'b0;
        @(negedge clk);
        chk("midrst_data", 32'(d1_data), 32'h0);
        chk("midrst_cnt", 32'(d1_cnt), 32'h0);
        chk("midrst_busy", 32'(d1_busy), 32'h0);
        @(posedge clk); #1 rst_n1 = 1'b1;
        t0 = cyc;
        expect_fetch(13'h040, 16'd1, t0 + 3);
        wait_done(4);
        chk("refetch_data", 32'(d1_data), 32'hF5);

        @(posedge clk); #1 rst_n1 = 1'b0; ppu_rd = 1'b0;
        @(posedge clk); #1 rst_n3 = 1'b1;
        drive(14'h0050, 1'b1);
        t0 = cyc;
        expect_fetch(13'h050, 16'd1, t0 + 5);
        expect_fetch(13'h060, 16'd2, t0 + 10);
        @(posedge clk); #1;
        @(posedge clk); #1 ppu_addr = 14'h0060;
        wait_done(6);
        chk("lat3_second_data", 32'(d3_data), 32'hD5);
        m = men3;
        idle_cycles(10);
        chk("lat3_no_extra_mem_en", 32'(men3), 32'(m));
        chk("lat3_cnt", 32'(d3_cnt), 32'd2);

        chk("addr_queue_empty", 32'(qa.size()), 32'd0);
        chk("data_queue_empty", 32'(qd.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
